pc_sequencer: RTL and testbench
===============================

# pc_sequencer

- Program-counter stage of the core; sits directly upstream of the return-address stack.
- Holds the current word-addressed PC and advances it each cycle by next/jump/branch/call/return/halt decode.
- On call, pushes the return address (PC+1) to the stack; on return, pops it and reloads the PC.
- Watches the stack overflow flag and can enter a fault state.

## Interface
- ADDR_W, 32, PC and stack data width
- RESET_PC, 0, PC value loaded on reset
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  freezes PC and suppresses stack ops while in RUN
- op  in  3  sequencing op: NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4, HALT=5; 6/7 treated as NEXT
- branchTaken  in  1  qualifies BRANCH
- target  in  ADDR_W  absolute target for JUMP/BRANCH/CALL
- pc  out  ADDR_W  current PC
- pcValid  out  1  pc is a fetchable address this cycle
- writeStack  out  1  push request to stack
- readStack  out  1  pop request to stack
- stackPc  out  ADDR_W  value to push; always pc+1
- stackOut  in  ADDR_W  popped value; valid the cycle after readStack
- stackOverflow  in  1  stack over/underflow flag
- fault  out  1  sequencer halted on a stack error

## Operation
- States: RUN, RET_WAIT, HALTED, FAULT.
- An op is accepted only in RUN with stall low. With stall high in RUN, pc holds and writeStack/readStack are 0.
- PC update on acceptance, all sums modulo 2^ADDR_W:
  - NEXT: pc+1.
  - JUMP: target.
  - BRANCH: target if branchTaken, else pc+1.
  - CALL: target. writeStack=1 in the same cycle with stackPc=pc+1.
  - RET: readStack=1. Goes to RET_WAIT; pc holds.
  - HALT: pc holds. Goes to HALTED.
- RET_WAIT:
  - pcValid=0.
  - At the closing edge, pc loads stackOut and the state returns to RUN.
  - stall and op are ignored.
- HALTED: pcValid=0, stack ops 0. Left only by reset.
- FAULT: pcValid=0, fault=1, stack ops 0, pc frozen. Left only by reset.
- writeStack and readStack are combinational from state, stall and op, and are never both 1.
- Reset values: pc=RESET_PC, state RUN, pcValid=1, fault=0. writeStack and readStack are 0 while reset is low.

## Timing
- NEXT/JUMP/BRANCH/CALL: new pc visible one cycle after acceptance.
- RET: two cycles from acceptance to the new pc. Cycle 1 asserts readStack; cycle 2 is RET_WAIT; pc=stackOut after that edge.
- Error check: the cycle following any push or pop is flagged by an internal stackOpPending register.
  - Flagged cycle with stackOverflow high: enter FAULT at the next edge. This overrides the RET_WAIT load and any op in that cycle.
  - stackOverflow outside flagged cycles is ignored.
- Back-to-back CALLs push on consecutive cycles.
- A RET directly after a CALL pops the just-pushed value.
- Reset asserted mid-RET_WAIT: abort immediately; the popped value is discarded.

## Configuration
- STACK_FAULT_EN defined: overflow checking as above, FAULT state reachable.
- STACK_FAULT_EN undefined: stackOverflow is ignored, stackOpPending is not built, and fault is tied to 0.
  - A pop from an empty stack then loads whatever stackOut presents.

## Structure
- Shared package musa_pc_pkg holds:
  - pc_op_t enum (NEXT..HALT).
  - pc_state_t enum.
  - the ADDR_W default constant.
- One natural sub-module: pc_next_mux. It is combinational; from op, branchTaken, target and pc it produces the next-PC value and the push/pop strobes.
- The FSM and registers stay in pc_sequencer.

## Test plan
- Reset release with RESET_PC=100, 4 cycles of NEXT -> pc 100,101,102,103,104; pcValid=1; no stack strobes.
- pc=100, CALL target=200 -> writeStack=1, stackPc=101 that cycle; pc=200 next cycle. Then RET with stackOut=101 -> readStack=1 for one cycle, pcValid=0 for one cycle, then pc=101.
- BRANCH target=50 at pc=10: branchTaken=0 -> pc=11; branchTaken=1 -> pc=50. With stall=1 on a CALL -> pc holds, writeStack stays 0.
- pc=2^ADDR_W-1, NEXT -> pc=0. CALL at the same pc -> stackPc=0.
- STACK_FAULT_EN defined, RET with stackOverflow=1 in RET_WAIT -> fault=1, pcValid=0, pc unchanged; further ops ignored until reset low clears to pc=RESET_PC. Without the macro -> pc loads stackOut and fault stays 0.
- HALT at pc=40 -> pc stays 40, pcValid=0 for 10 cycles despite NEXT ops. Async reset mid-cycle -> pc=RESET_PC immediately.

Source files
------------

// File: rtl/musa_pc_pkg.sv
// Shared types for the program-counter stage: sequencing ops, FSM states, default width.
package musa_pc_pkg;

  localparam int DEFAULT_ADDR_W = 32;

  // Encodings 6 and 7 are not named; decoders treat them as OP_NEXT.
  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HALT   = 3'd5
  } pc_op_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALTED   = 2'd2,
    ST_FAULT    = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select and raw push/pop decode; the caller qualifies
// the strobes with its own accept condition.
module pc_next_mux
  import musa_pc_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [2:0]        op,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_inc,
  output logic              push,
  output logic              pop
);

  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    next_pc = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    case (op)
      OP_JUMP:   next_pc = target;
      OP_BRANCH: next_pc = branch_taken ? target : pc_inc;
      OP_CALL: begin
        next_pc = target;
        push    = 1'b1;
      end
      // RET holds pc here; the popped address is loaded from RET_WAIT.
      OP_RET: begin
        next_pc = pc;
        pop     = 1'b1;
      end
      OP_HALT:   next_pc = pc;
      default:   next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding the return-address stack: RUN/RET_WAIT/HALTED/FAULT FSM.
// Define STACK_FAULT_EN to check stackOverflow the cycle after each push/pop and trap into FAULT.
module pc_sequencer
  import musa_pc_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        op,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              pcValid,
  output logic              writeStack,
  output logic              readStack,
  output logic [ADDR_W-1:0] stackPc,
  input  logic [ADDR_W-1:0] stackOut,
  input  logic              stackOverflow,
  output logic              fault
);

  pc_state_t         state;
  logic              accept;
  logic [ADDR_W-1:0] mux_pc;
  logic              mux_push;
  logic              mux_pop;
  logic              stack_err;

  assign accept = (state == ST_RUN) && !stall;

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_next_mux (
    .op           (op),
    .branch_taken (branchTaken),
    .target       (target),
    .pc           (pc),
    .next_pc      (mux_pc),
    .pc_inc       (stackPc),
    .push         (mux_push),
    .pop          (mux_pop)
  );

  // Gated by reset so the stack sees no strobe while the FSM is held in reset.
  assign writeStack = reset && accept && mux_push;
  assign readStack  = reset && accept && mux_pop;

`ifdef STACK_FAULT_EN
  logic stackOpPending;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stackOpPending <= 1'b0;
    end else begin
      stackOpPending <= writeStack || readStack;
    end
  end

  assign stack_err = stackOpPending && stackOverflow;
  assign fault     = (state == ST_FAULT);
`else
  logic unused_overflow;

  assign unused_overflow = stackOverflow;
  assign stack_err       = 1'b0;
  assign fault           = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      pcValid <= 1'b1;
    end else if (stack_err) begin
      // A stack error wins over the RET_WAIT reload and any op this cycle.
      state   <= ST_FAULT;
      pcValid <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!stall) begin
            pc <= mux_pc;
            if (op == OP_RET) begin
              state   <= ST_RET_WAIT;
              pcValid <= 1'b0;
            end else if (op == OP_HALT) begin
              state   <= ST_HALTED;
              pcValid <= 1'b0;
            end
          end
        end
        ST_RET_WAIT: begin
          pc      <= stackOut;
          state   <= ST_RUN;
          pcValid <= 1'b1;
        end
        default: begin
          pcValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model and a bench-side return stack.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'd100;
  localparam logic [31:0] EMPTY_POP = 32'hDEAD_BEEF;
`ifdef STACK_FAULT_EN
  localparam bit FAULT_BUILD = 1'b1;
`else
  localparam bit FAULT_BUILD = 1'b0;
`endif

  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2, M_FAULT = 3;

  logic        clock;
  logic        reset;
  logic        stall;
  logic [2:0]  op;
  logic        branchTaken;
  logic [31:0] target;
  logic [31:0] pc;
  logic        pcValid;
  logic        writeStack;
  logic        readStack;
  logic [31:0] stackPc;
  logic [31:0] stackOut;
  logic        stackOverflow;
  logic        fault;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  int          m_mode;
  logic [31:0] m_pc;
  bit          m_flag;
  logic [31:0] stk[$];
  logic [31:0] pop_val;

  pc_sequencer #(
    .ADDR_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .op            (op),
    .branchTaken   (branchTaken),
    .target        (target),
    .pc            (pc),
    .pcValid       (pcValid),
    .writeStack    (writeStack),
    .readStack     (readStack),
    .stackPc       (stackPc),
    .stackOut      (stackOut),
    .stackOverflow (stackOverflow),
    .fault         (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit exp_push();
    return reset && m_mode == M_RUN && !stall && op == 3'd3;
  endfunction

  function automatic bit exp_pop();
    return reset && m_mode == M_RUN && !stall && op == 3'd4;
  endfunction

  // Reference model: what each edge must do, plus the stack the DUT talks to.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc    = RST_PC;
      m_mode  = M_RUN;
      m_flag  = 1'b0;
      pop_val = EMPTY_POP;
      stk.delete();
    end else begin
      bit          push, pop, err;
      logic [31:0] cur;
      push   = exp_push();
      pop    = exp_pop();
      cur    = m_pc;
      err    = FAULT_BUILD && m_flag && stackOverflow;
      m_flag = push || pop;
      if (err) m_mode = M_FAULT;
      else if (m_mode == M_WAIT) begin
        m_pc   = stackOut;
        m_mode = M_RUN;
      end else if (m_mode == M_RUN && !stall) begin
        case (op)
          3'd1: m_pc = target;
          3'd2: m_pc = branchTaken ? target : cur + 32'd1;
          3'd3: m_pc = target;
          3'd4: m_mode = M_WAIT;
          3'd5: m_mode = M_HALT;
          default: m_pc = cur + 32'd1;
        endcase
      end
      if (push) stk.push_back(cur + 32'd1);
      if (pop) pop_val = (stk.size() > 0) ? stk.pop_back() : EMPTY_POP;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cmp_pc", pc, m_pc);
      chk("cmp_pcValid", {31'd0, pcValid}, {31'd0, m_mode == M_RUN});
      chk("cmp_fault", {31'd0, fault}, {31'd0, m_mode == M_FAULT});
      chk("cmp_writeStack", {31'd0, writeStack}, {31'd0, exp_push()});
      chk("cmp_readStack", {31'd0, readStack}, {31'd0, exp_pop()});
      chk("cmp_stackPc", stackPc, m_pc + 32'd1);
    end
  end

  task automatic drive(input logic [2:0] o, input logic [31:0] t = 32'd0,
                       input bit tk = 1'b0, input bit st = 1'b0, input bit ov = 1'b0);
    op            = o;
    target        = t;
    branchTaken   = tk;
    stall         = st;
    stackOverflow = ov;
    stackOut      = pop_val;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pop_val = EMPTY_POP;
    drive(3'd0);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    tick();
    tick();
    reset = 1'b1;

    // Reset release and straight-line NEXT
    for (int i = 0; i < 4; i++) begin
      drive(3'd0);
      #1;
      chk("next_pc", pc, RST_PC + i);
      chk("next_valid", {31'd0, pcValid}, 32'd1);
      chk("next_nostrobe", {30'd0, writeStack, readStack}, 32'd0);
      tick();
    end
    drive(3'd1, 32'd100);
    #1 chk("next_pc_end", pc, 32'd104);
    tick();

    // CALL then RET
    drive(3'd3, 32'd200);
    #1 chk("call_ws", {31'd0, writeStack}, 32'd1);
    chk("call_stackPc", stackPc, 32'd101);
    tick();
    drive(3'd4);
    #1 chk("call_pc", pc, 32'd200);
    chk("ret_rs", {31'd0, readStack}, 32'd1);
    tick();
    drive(3'd0);
    #1 chk("retwait_valid", {31'd0, pcValid}, 32'd0);
    chk("retwait_rs", {31'd0, readStack}, 32'd0);
    tick();
    drive(3'd1, 32'd10);
    #1 chk("ret_pc", pc, 32'd101);
    chk("ret_valid", {31'd0, pcValid}, 32'd1);
    tick();

    // BRANCH not taken / taken, stalled CALL
    drive(3'd2, 32'd50, 1'b0);
    tick();
    drive(3'd1, 32'd10);
    #1 chk("br_nt_pc", pc, 32'd11);
    tick();
    drive(3'd2, 32'd50, 1'b1);
    tick();
    drive(3'd3, 32'd77, 1'b0, 1'b1);
    #1 chk("br_t_pc", pc, 32'd50);
    chk("stall_ws", {31'd0, writeStack}, 32'd0);
    tick();
    drive(3'd1, 32'hFFFF_FFFF);
    #1 chk("stall_pc", pc, 32'd50);
    tick();

    // Wrap at the top of the address space
    drive(3'd0);
    tick();
    drive(3'd1, 32'hFFFF_FFFF);
    #1 chk("wrap_pc", pc, 32'd0);
    tick();
    drive(3'd3, 32'd5);
    #1 chk("wrap_stackPc", stackPc, 32'd0);
    tick();
    drive(3'd4);
    tick();
    drive(3'd0);
    tick();

    // Back-to-back CALLs, RETs unwind in order
    drive(3'd3, 32'd300);
    #1 chk("wrap_ret_pc", pc, 32'd0);
    tick();
    drive(3'd3, 32'd400);
    #1 chk("b2b_stackPc", stackPc, 32'd301);
    tick();
    drive(3'd4);
    tick();
    drive(3'd4);
    #1 chk("wait_ignores_ret", {31'd0, readStack}, 32'd0);
    tick();
    drive(3'd4);
    #1 chk("b2b_ret1_pc", pc, 32'd301);
    tick();
    drive(3'd0);
    tick();
    drive(3'd6);
    #1 chk("b2b_ret2_pc", pc, 32'd1);
    tick();
    drive(3'd7);
    tick();
    drive(3'd0);
    #1 chk("op67_pc", pc, 32'd3);
    tick();

    // Stray overflow ignored; overflow in RET_WAIT traps only with checking built in
    drive(3'd1, 32'd590);
    tick();
    drive(3'd3, 32'd600, 1'b0, 1'b0, 1'b1);
    #1 chk("ovf_call_stackPc", stackPc, 32'd591);
    tick();
    drive(3'd4);
    #1 chk("stray_ovf_fault", {31'd0, fault}, 32'd0);
    tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(3'd3, 32'd700);
    #1 chk("ovf_pc", pc, FAULT_BUILD ? 32'd600 : 32'd591);
    chk("ovf_fault", {31'd0, fault}, {31'd0, FAULT_BUILD});
    chk("ovf_valid", {31'd0, pcValid}, {31'd0, !FAULT_BUILD});
    chk("ovf_ws", {31'd0, writeStack}, {31'd0, !FAULT_BUILD});
    tick();
    drive(3'd3, 32'd700);
    tick();
    drive(3'd0);
    #1 chk("ovf_after_pc", pc, FAULT_BUILD ? 32'd600 : 32'd700);
    #2 reset = 1'b0;
    #1 chk("fault_rst_pc", pc, RST_PC);
    chk("fault_rst_fault", {31'd0, fault}, 32'd0);
    tick();
    reset = 1'b1;

    // HALT holds pc regardless of ops, async reset leaves it
    drive(3'd1, 32'd40);
    tick();
    drive(3'd5);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(3'd0);
      #1;
      chk("halt_pc", pc, 32'd40);
      chk("halt_valid", {31'd0, pcValid}, 32'd0);
      tick();
    end
    drive(3'd0);
    #3 reset = 1'b0;
    #1 chk("halt_rst_pc", pc, RST_PC);
    chk("halt_rst_valid", {31'd0, pcValid}, 32'd1);
    tick();
    reset = 1'b1;

    // Reset in RET_WAIT drops the pop
    drive(3'd1, 32'd800);
    tick();
    drive(3'd3, 32'd900);
    tick();
    drive(3'd4);
    tick();
    drive(3'd0);
    #1 chk("abort_wait_valid", {31'd0, pcValid}, 32'd0);
    #2 reset = 1'b0;
    #1 chk("abort_pc", pc, RST_PC);
    tick();
    reset = 1'b1;
    drive(3'd0);
    tick();
    drive(3'd0);
    #1 chk("abort_next_pc", pc, 32'd101);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
